// File: rtl/crc32_fcs_engine.sv
// crc32_fcs_engine
//   Avalon-ST CRC-32 (IEEE 802.3 FCS) engine, P_BYTES lanes per beat,
//   lane 0 first on the wire.
//   P_MODE = 0: check mode. Stream passes through one cycle later; on EOP
//     the output error flag is raised if the frame is shorter than 4 bytes
//     or its CRC residue is wrong. good_frames/bad_frames count EOPs.
//   P_MODE = 1: insert mode. FCS is appended after the payload, using
//     empty lanes of the EOP beat first and extra beats (ready low) after.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   stream_in_*                 Avalon-ST sink (valid/ready handshake)
//   stream_out_*                Avalon-ST source, all registered
//   cnt_clear                   zero both frame counters
//   good_frames, bad_frames     saturating 16-bit frame counters
module crc32_fcs_engine #(
  parameter int          P_BYTES   = 1,
  parameter int          P_MODE    = 0,
  parameter logic [31:0] P_RESIDUE = 32'hC704DD7B,
  localparam int         EW        = (P_BYTES > 1) ? $clog2(P_BYTES) : 1,
  localparam int         DW        = 8 * P_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stream_in_valid,
  input  logic          stream_in_startofpacket,
  input  logic          stream_in_endofpacket,
  input  logic          stream_in_error,
  input  logic [DW-1:0] stream_in_data,
  input  logic [EW-1:0] stream_in_empty,
  output logic          stream_in_ready,
  output logic          stream_out_valid,
  output logic          stream_out_startofpacket,
  output logic          stream_out_endofpacket,
  output logic          stream_out_error,
  output logic [DW-1:0] stream_out_data,
  output logic [EW-1:0] stream_out_empty,
  input  logic          cnt_clear,
  output logic [15:0]   good_frames,
  output logic [15:0]   bad_frames
);

  localparam int unsigned   NB   = P_BYTES;
  localparam logic [31:0]   POLY = 32'h04C11DB7;
  localparam logic [31:0]   INIT = '1;
  localparam logic [DW-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_APPEND} state_t;

  // CRC register is kept MSB-first; each byte is fed bit 0 first, so the
  // good-frame residue is the bit-reversed form of 0xDEBB20E3.
  function automatic logic [31:0] crc_lanes(input logic [31:0] c,
                                            input logic [DW-1:0] d,
                                            input int unsigned n);
    logic [31:0] r;
    logic [7:0]  b;
    logic        fb;
    r = c;
    for (int unsigned l = 0; l < NB; l++) begin
      b = 8'(d >> (8 * l));
      if (l < n) begin
        for (int unsigned k = 0; k < 8; k++) begin
          fb = r[31] ^ b[0];
          r  = {r[30:0], 1'b0} ^ (fb ? POLY : '0);
          b  = b >> 1;
        end
      end
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic            in_pkt_q, in_pkt_d;
  logic [2:0]      len_q, len_d;     // bytes seen in frame, saturates at 4
  logic [31:0]     fcs_q, fcs_d;     // FCS bytes still to send, next in [7:0]
  logic [2:0]      rem_q, rem_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            ov_q, ov_d, osop_q, osop_d, oeop_q, oeop_d, oerr_q, oerr_d;
  logic [DW-1:0]   odata_q, odata_d;
  logic [EW-1:0]   oempty_q, oempty_d;
  logic [15:0]     good_q, good_d, bad_q, bad_d;

  logic            acc, active, frame_bad, last;
  int unsigned     e_i, nl, len_sum;
  logic [31:0]     crc_new, fcs_w;
  logic [DW-1:0]   masked;

  always_comb begin
    acc       = stream_in_valid & ready_q;
    active    = acc & (stream_in_startofpacket | in_pkt_q);
    e_i       = 32'(stream_in_empty);
    nl        = stream_in_endofpacket ? NB - e_i : NB;
    crc_new   = crc_lanes(stream_in_startofpacket ? INIT : crc_q, stream_in_data, nl);
    len_sum   = (stream_in_startofpacket ? 32'd0 : 32'(len_q)) + nl;
    frame_bad = !active || (len_sum < 4) || (crc_new != P_RESIDUE);
    fcs_w     = {<<{~crc_new}};
    masked    = stream_in_data & (ONES >> (8 * e_i));
    last      = 1'b0;

    state_d  = state_q;
    crc_d    = active ? crc_new : crc_q;
    len_d    = active ? 3'((len_sum >= 4) ? 4 : len_sum) : len_q;
    in_pkt_d = in_pkt_q;
    if (acc) in_pkt_d = stream_in_endofpacket ? 1'b0 : (stream_in_startofpacket | in_pkt_q);
    fcs_d    = fcs_q;
    rem_d    = rem_q;
    err_d    = err_q;
    ready_d  = 1'b1;
    ov_d     = acc;
    osop_d   = stream_in_startofpacket;
    oeop_d   = stream_in_endofpacket;
    oerr_d   = stream_in_error;
    odata_d  = stream_in_data;
    oempty_d = stream_in_empty;
    good_d   = good_q;
    bad_d    = bad_q;

    if (P_MODE == 0) begin
      if (stream_in_endofpacket) oerr_d = stream_in_error | frame_bad;
      if (acc && stream_in_endofpacket) begin
        if (oerr_d) bad_d  = (bad_q  == '1) ? bad_q  : bad_q  + 16'd1;
        else        good_d = (good_q == '1) ? good_q : good_q + 16'd1;
      end
    end else begin
      case (state_q)
        S_APPEND: begin
          last     = 32'(rem_q) <= NB;
          ov_d     = 1'b1;
          osop_d   = 1'b0;
          odata_d  = DW'(fcs_q);
          oeop_d   = last;
          oempty_d = last ? EW'(NB - 32'(rem_q)) : '0;
          oerr_d   = last & err_q;
          fcs_d    = fcs_q >> (8 * NB);
          rem_d    = 3'(32'(rem_q) - NB);
          state_d  = last ? S_IDLE : S_APPEND;
        end
        default: begin
          state_d = in_pkt_d ? S_PASS : S_IDLE;
          if (active && stream_in_endofpacket) begin
            // FCS byte 0 lands in the first empty lane; bytes shifted past
            // the top lane are carried into the APPEND beats.
            odata_d = masked | DW'({{DW{1'b0}}, fcs_w} << (8 * (NB - e_i)));
            if (e_i >= 4) begin
              oempty_d = EW'(e_i - 4);
            end else begin
              oeop_d   = 1'b0;
              oempty_d = '0;
              oerr_d   = 1'b0;
              err_d    = stream_in_error;
              fcs_d    = fcs_w >> (8 * e_i);
              rem_d    = 3'(4 - e_i);
              state_d  = S_APPEND;
            end
          end
        end
      endcase
      ready_d = (state_d != S_APPEND);
    end

    if (cnt_clear) begin
      good_d = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      crc_q    <= INIT;
      in_pkt_q <= 1'b0;
      len_q    <= '0;
      fcs_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      ov_q     <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      oerr_q   <= 1'b0;
      odata_q  <= '0;
      oempty_q <= '0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      in_pkt_q <= in_pkt_d;
      len_q    <= len_d;
      fcs_q    <= fcs_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      ov_q     <= ov_d;
      osop_q   <= osop_d;
      oeop_q   <= oeop_d;
      oerr_q   <= oerr_d;
      odata_q  <= odata_d;
      oempty_q <= oempty_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  assign stream_in_ready          = ready_q;
  assign stream_out_valid         = ov_q;
  assign stream_out_startofpacket = osop_q;
  assign stream_out_endofpacket   = oeop_q;
  assign stream_out_error         = oerr_q;
  assign stream_out_data          = odata_q;
  assign stream_out_empty         = oempty_q;
  assign good_frames              = good_q;
  assign bad_frames               = bad_q;

endmodule
